uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, meaning clk cycles per serial bit (minimum 4).
REQ-002 SHALL have parameter FIFO_AW, default 4, meaning log2 of the FIFO depth (16 entries).
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All state SHALL be on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rxd, input, 1 bit: asynchronous serial line, 8N1 format, idle high.
REQ-006 SHALL have port rd_en, input, 1 bit: pop request for the FIFO head.
REQ-007 SHALL have port rd_data, output, 8 bits: FIFO head byte (show-ahead).
REQ-008 SHALL have port recv_flag, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port count, output, FIFO_AW+1 bits: current FIFO occupancy.
REQ-010 SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, byte dropped because the FIFO was full.
REQ-012 SHALL have port err_clr, input, 1 bit: clears frame_err and overrun.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer whose flops reset to 1; all sampling SHALL use the synchronized value.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: a synchronized low SHALL go to START and load the bit counter with BAUD_DIV/2 - 1 (integer division).
REQ-016 START: when the counter reaches 0, a sampled high SHALL return to IDLE (glitch reject, nothing pushed); a sampled low SHALL go to DATA with counter BAUD_DIV-1 and bit index 0.
REQ-017 DATA: each time the counter reaches 0, SHALL sample one bit into the shift register LSB-first and reload BAUD_DIV-1; after bit index 7 is sampled SHALL go to STOP.
REQ-018 STOP: at counter 0 with a sampled high, SHALL push the byte and go to IDLE.
REQ-019 STOP: at counter 0 with a sampled low, SHALL discard the byte, set frame_err, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL stay until the synchronized rxd is 1, then go to IDLE (break condition produces one frame_err only).
REQ-021 The FIFO SHALL have 2^FIFO_AW entries with wrapping read and write pointers of FIFO_AW bits.
REQ-022 count SHALL be FIFO_AW+1 bits wide and range 0..2^FIFO_AW.
REQ-023 A push SHALL be visible on recv_flag, count and rd_data in the cycle after the stop-bit sample edge.
REQ-024 rd_data SHALL equal the head entry whenever recv_flag=1; its value while empty is don't-care.
REQ-025 rd_en=1 with recv_flag=1 SHALL pop at the clock edge; rd_en while empty SHALL be ignored (pointers and count unchanged).
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; this SHALL also hold when full (no overrun) and when empty-with-push (pop ignored, count+1).
REQ-027 A push while full without a simultaneous pop SHALL drop the new byte, keep FIFO contents, and set overrun.
REQ-028 err_clr=1 SHALL clear both sticky flags at the next edge; if a set event coincides with err_clr, set SHALL win.
REQ-029 The receiver SHALL keep running while the FIFO is full; only the push is suppressed.

Reset
REQ-030 While rst=1, SHALL hold FSM=IDLE, counters 0, pointers 0, count=0, recv_flag=0, frame_err=0, overrun=0, rd_data=8'h00, and synchronizer flops =1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no push; after release a frame SHALL be recognised only from a fresh falling edge.

Verification (BAUD_DIV=8, FIFO_AW=4)
REQ-032 Send 8N1 frame 0x55 -> recv_flag rises once, count=1, rd_data=8'h55; pulse rd_en one cycle -> count=0, recv_flag=0.
REQ-033 Drive rxd low for 2 cycles in IDLE -> no push, count stays 0, frame_err stays 0.
REQ-034 Send 0xA3 with stop bit low, then hold line low for 3 bit times -> frame_err=1 exactly once, count=0; pulse err_clr -> frame_err=0.
REQ-035 Send 17 frames 0x00..0x10 with no reads -> count=16, overrun=1; reads return 0x00..0x0F in order, then recv_flag=0.
REQ-036 With the FIFO full, assert rd_en on the cycle of the 17th push -> count stays 16, overrun stays 0, last entry=17th byte.
REQ-037 Assert rst during DATA bit 4, release, then send 0x3C -> only 0x3C is received, count=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO.
// Includes sticky frame-error and overrun flags, cleared by err_clr.
module uart_rx_fifo #(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               recv_flag,
  output logic [FIFO_AW:0]   count,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clr
);

  localparam int CW    = $clog2(BAUD_DIV);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic [7:0]          shift, shift_nxt;
  logic                rx_meta, rx_sync;
  logic                push, frame_set;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic                full, do_push, do_pop, overrun_set;

  // Synchronizer flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push        = 1'b0;
    frame_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_nxt = START;
          cnt_nxt   = CW'(BAUD_DIV / 2 - 1);
        end
      end
      // Half-bit delay lands all later samples near bit centres.
      START: begin
        if (cnt == '0) begin
          if (rx_sync) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            cnt_nxt     = CW'(BAUD_DIV - 1);
            bit_idx_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_nxt   = {rx_sync, shift[7:1]};
          cnt_nxt     = CW'(BAUD_DIV - 1);
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_sync) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_set = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign recv_flag   = (count != '0);
  assign full        = (count == (FIFO_AW + 1)'(DEPTH));
  assign do_pop      = rd_en && recv_flag;
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !do_pop;
  assign rd_data     = recv_flag ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (overrun_set)  overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with BAUD_DIV=8, FIFO_AW=4.
// Frames are driven on falling edges; outputs are sampled on falling edges.
module tb_uart_rx_fifo;

  localparam int BAUD = 8;
  localparam int AW   = 4;

  logic          clk;
  logic          rst;
  logic          rxd;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          recv_flag;
  logic [AW:0]   count;
  logic          frame_err;
  logic          overrun;
  logic          err_clr;

  int pass_cnt  = 0;
  int check_cnt = 0;

  uart_rx_fifo #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .recv_flag (recv_flag),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one full 8N1 frame; optionally raises rd_en on the cycle of the stop-bit sample.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic pop_at_push);
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BAUD) @(negedge clk);
    end
    rxd = stop_bit;
    if (pop_at_push) begin
      repeat (BAUD - 2) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
    end else begin
      repeat (BAUD) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic popOne;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rxd     = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_count", 16'(count), 16'd0);
    checkOutput("reset_recv_flag", 16'(recv_flag), 16'd0);
    checkOutput("reset_frame_err", 16'(frame_err), 16'd0);
    checkOutput("reset_overrun", 16'(overrun), 16'd0);
    checkOutput("reset_rd_data", 16'(rd_data), 16'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame 0x55
    applyStimulus(8'h55, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("f55_recv_flag", 16'(recv_flag), 16'd1);
    checkOutput("f55_count", 16'(count), 16'd1);
    checkOutput("f55_rd_data", 16'(rd_data), 16'h55);
    repeat (40) @(negedge clk);
    checkOutput("f55_count_stable", 16'(count), 16'd1);
    popOne();
    checkOutput("f55_pop_count", 16'(count), 16'd0);
    checkOutput("f55_pop_recv_flag", 16'(recv_flag), 16'd0);
    popOne();
    checkOutput("empty_pop_count", 16'(count), 16'd0);

    // Two-cycle glitch must be rejected
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitch_count", 16'(count), 16'd0);
    checkOutput("glitch_frame_err", 16'(frame_err), 16'd0);

    // Bad stop bit followed by a break
    applyStimulus(8'hA3, 1'b0, 1'b0);
    rxd = 1'b0;
    checkOutput("ferr_set", 16'(frame_err), 16'd1);
    checkOutput("ferr_count", 16'(count), 16'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("ferr_clear", 16'(frame_err), 16'd0);
    repeat (3 * BAUD - 1) @(negedge clk);
    rxd = 1'b1;
    repeat (120) @(negedge clk);
    checkOutput("break_single_ferr", 16'(frame_err), 16'd0);
    checkOutput("break_count", 16'(count), 16'd0);

    // 17 frames into a 16-deep FIFO
    for (int b = 0; b < 17; b++) applyStimulus(8'(b), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("full_count", 16'(count), 16'd16);
    checkOutput("full_overrun", 16'(overrun), 16'd1);
    for (int b = 0; b < 16; b++) begin
      checkOutput("drain_rd_data", 16'(rd_data), 16'(b));
      popOne();
    end
    checkOutput("drain_recv_flag", 16'(recv_flag), 16'd0);
    checkOutput("drain_count", 16'(count), 16'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("ovr_clear", 16'(overrun), 16'd0);

    // Full FIFO with a pop on the push cycle
    for (int b = 0; b < 16; b++) applyStimulus(8'h20 + 8'(b), 1'b1, 1'b0);
    applyStimulus(8'h30, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("simul_count", 16'(count), 16'd16);
    checkOutput("simul_overrun", 16'(overrun), 16'd0);
    for (int b = 0; b < 16; b++) begin
      checkOutput("simul_rd_data", 16'(rd_data), 16'(8'h21 + 8'(b)));
      popOne();
    end
    checkOutput("simul_empty", 16'(recv_flag), 16'd0);

    // Reset during data bit 4 of an aborted frame
    rxd = 1'b0;
    repeat (BAUD + 4 * BAUD + 4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    checkOutput("midrst_rd_data", 16'(rd_data), 16'h00);
    checkOutput("midrst_count", 16'(count), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("postrst_count", 16'(count), 16'd0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("f3c_count", 16'(count), 16'd1);
    checkOutput("f3c_rd_data", 16'(rd_data), 16'h3C);
    checkOutput("f3c_frame_err", 16'(frame_err), 16'd0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
